seq_det_sched: RTL and testbench

Round-robin scheduler that shares one serial pattern detector (1101, overlapping, Moore output) among NREQ requesters. It grants one requester at a time and latches that requester's WORD_W-bit word. It clears the detector, shifts the word into it MSB-first with valid, then counts the detector hits. The hit count and requester id are returned on a ready/valid result port. It sits between the requester-side word sources and the shared detector instance.

---
 rtl/seq_det_sched.sv | 112 +++++++++++
 tb/tb_seq_det_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_det_sched.sv
// Round-robin scheduler sharing one serial 1101 detector among NREQ requesters.
// It grants one requester, shifts that requester's word out MSB-first and reports the hit count.
module seq_det_sched #(
    parameter int  NREQ    = 4,
    parameter int  WORD_W  = 8,
    parameter int  DET_LAT = 1,
    parameter int  CNT_W   = 4,
    localparam int ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   res,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*WORD_W-1:0] word_in,
    output logic [NREQ-1:0]        gnt,
    output logic                   det_clr,
    output logic                   det_d_in,
    output logic                   det_valid,
    input  logic                   det_hit,
    output logic                   res_valid,
    output logic [ID_W-1:0]        res_id,
    output logic [CNT_W-1:0]       res_count,
    input  logic                   res_ready,
    output logic                   busy
);
    localparam int MAX_CYC = (WORD_W > DET_LAT) ? WORD_W : DET_LAT;
    localparam int CYC_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, REPORT} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ID_W-1:0]   r_ptr;
    logic [ID_W-1:0]   r_id;
    logic [ID_W-1:0]   w_gnt_idx;
    logic              w_any;
    logic [WORD_W-1:0] r_shift;
    logic [CYC_W-1:0]  r_cyc;
    logic [CNT_W-1:0]  r_count;

    // Search downward from pointer+NREQ so the requester nearest to pointer+1 is written last and wins.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(r_ptr) + k) % NREQ]) begin
                w_any     = 1'b1;
                w_gnt_idx = ID_W'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        gnt    = '0;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_next = CLEAR;
                    gnt    = NREQ'(1) << w_gnt_idx;
                end
            end
            CLEAR:   w_next = SHIFT;
            SHIFT:   if (r_cyc == CYC_W'(WORD_W - 1)) w_next = DRAIN;
            DRAIN:   if (r_cyc == CYC_W'(DET_LAT - 1)) w_next = REPORT;
            REPORT:  if (res_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Detector-side outputs come from registered state only, never from inputs.
    assign det_clr   = (r_state == CLEAR);
    assign det_valid = (r_state == SHIFT);
    assign det_d_in  = (r_state == SHIFT) && r_shift[WORD_W-1];
    assign res_valid = (r_state == REPORT);
    assign res_id    = r_id;
    assign res_count = r_count;
    assign busy      = (r_state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            r_state <= IDLE;
            r_ptr   <= ID_W'(NREQ - 1);
            r_id    <= '0;
            r_shift <= '0;
            r_cyc   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_shift <= word_in[int'(w_gnt_idx)*WORD_W +: WORD_W];
                        r_id    <= w_gnt_idx;
                        r_ptr   <= w_gnt_idx;
                        r_count <= '0;
                        r_cyc   <= '0;
                    end
                end
                SHIFT: begin
                    r_shift <= r_shift << 1;
                    r_cyc   <= (r_cyc == CYC_W'(WORD_W - 1)) ? '0 : r_cyc + 1'b1;
                end
                DRAIN:   r_cyc <= r_cyc + 1'b1;
                default: ;
            endcase
            if ((r_state == SHIFT || r_state == DRAIN) && det_hit && (r_count != '1))
                r_count <= r_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: behavioural 1101 detectors, grant/result scoreboard,
// a vector table plus hand-written reset, stall, idle, fairness and saturation sequences.
module tb_seq_det_sched;
    localparam int NREQ    = 4;
    localparam int WORD_W  = 8;
    localparam int DET_LAT = 1;
    localparam int CNT_W   = 4;
    localparam int ID_W    = $clog2(NREQ);

    logic                   clk;
    logic                   rst_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*WORD_W-1:0] word_in;
    logic [NREQ-1:0]        gnt;
    logic                   det_clr, det_d_in, det_valid, det_hit;
    logic                   res_valid, res_ready, busy;
    logic [ID_W-1:0]        res_id;
    logic [CNT_W-1:0]       res_count;

    logic [NREQ-1:0]        s_req;
    logic [NREQ*WORD_W-1:0] s_word;
    logic [NREQ-1:0]        s_gnt;
    logic                   s_clr, s_d, s_valid, s_hit, s_rv, s_ready, s_busy;
    logic [ID_W-1:0]        s_rid;
    logic [0:0]             s_rcnt;

    int n_checks = 0;
    int n_fail   = 0;

    seq_det_sched #(.NREQ(NREQ), .WORD_W(WORD_W), .DET_LAT(DET_LAT), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .res(rst_n), .req(req), .word_in(word_in), .gnt(gnt),
        .det_clr(det_clr), .det_d_in(det_d_in), .det_valid(det_valid), .det_hit(det_hit),
        .res_valid(res_valid), .res_id(res_id), .res_count(res_count),
        .res_ready(res_ready), .busy(busy)
    );

    seq_det_sched #(.NREQ(NREQ), .WORD_W(WORD_W), .DET_LAT(DET_LAT), .CNT_W(1)) u_sat (
        .clk(clk), .res(rst_n), .req(s_req), .word_in(s_word), .gnt(s_gnt),
        .det_clr(s_clr), .det_d_in(s_d), .det_valid(s_valid), .det_hit(s_hit),
        .res_valid(s_rv), .res_id(s_rid), .res_count(s_rcnt),
        .res_ready(s_ready), .busy(s_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Moore 1101 detectors: registered 4-bit history, hit visible one cycle after the last bit.
    logic [3:0] hist_a, hist_b;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         hist_a <= '0;
        else if (det_clr)   hist_a <= '0;
        else if (det_valid) hist_a <= {hist_a[2:0], det_d_in};
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       hist_b <= '0;
        else if (s_clr)   hist_b <= '0;
        else if (s_valid) hist_b <= {hist_b[2:0], s_d};
    end
    assign det_hit = (hist_a == 4'b1101);
    assign s_hit   = (hist_b == 4'b1101);

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected", name);
    endtask

    function automatic int exp_hits(input logic [WORD_W-1:0] w, input int cw);
        logic [3:0] h = '0;
        int n = 0;
        for (int i = WORD_W - 1; i >= 0; i--) begin
            h = {h[2:0], w[i]};
            if (h == 4'b1101) n++;
        end
        if (n > (1 << cw) - 1) n = (1 << cw) - 1;
        return n;
    endfunction

    function automatic int next_grant(input logic [NREQ-1:0] r, input int ptr);
        for (int k = 1; k <= NREQ; k++)
            if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    // Scoreboard: expected result pushed at grant, compared while res_valid, popped on handshake.
    typedef struct {
        int id;
        int count;
        int gcyc;
    } exp_t;
    exp_t              sb[$];
    int                cyc = 0;
    int                exp_ptr = NREQ - 1;
    int                mon_bit = 0;
    logic [WORD_W-1:0] mon_word = '0;
    logic              prev_rv = 1'b0;

    always @(negedge clk) begin
        int g;
        #1;
        cyc++;
        if (!rst_n) begin
            sb.delete();
            exp_ptr = NREQ - 1;
            mon_bit = 0;
            prev_rv = 1'b0;
        end else begin
            if (gnt != '0) begin
                g = next_grant(req, exp_ptr);
                check("gnt_while_busy", int'(busy), 0);
                if (g < 0) begin
                    fail_now("gnt_without_req");
                end else begin
                    check("gnt_onehot", int'(gnt), 1 << g);
                    exp_ptr  = g;
                    mon_word = word_in[g*WORD_W +: WORD_W];
                    mon_bit  = 0;
                    sb.push_back('{g, exp_hits(mon_word, CNT_W), cyc});
                end
            end
            if (det_valid) begin
                if (mon_bit >= WORD_W) fail_now("det_valid_too_long");
                else check("det_d_in", int'(det_d_in), int'(mon_word[WORD_W-1-mon_bit]));
                mon_bit++;
            end
            if (res_valid) begin
                if (sb.size() == 0) begin
                    fail_now("res_valid_unexpected");
                end else begin
                    if (!prev_rv) begin
                        check("res_latency", cyc - sb[0].gcyc, WORD_W + 2 + DET_LAT);
                        check("shift_bits", mon_bit, WORD_W);
                    end
                    check("res_id", int'(res_id), sb[0].id);
                    check("res_count", int'(res_count), sb[0].count);
                    if (res_ready) void'(sb.pop_front());
                end
            end
            prev_rv = res_valid && !res_ready;
        end
    end

    task automatic wait_gnt(input int lim, output logic [NREQ-1:0] g);
        g = '0;
        for (int n = 0; n < lim; n++) begin
            #1;
            if (gnt != '0) begin
                g = gnt;
                return;
            end
            @(negedge clk);
        end
        fail_now("gnt_timeout");
    endtask

    task automatic wait_res(input int lim);
        for (int n = 0; n < lim; n++) begin
            #1;
            if (res_valid) return;
            @(negedge clk);
        end
        fail_now("res_valid_timeout");
    endtask

    task automatic wait_idle(input int lim);
        for (int n = 0; n < lim; n++) begin
            #1;
            if (!busy && !res_valid) return;
            @(negedge clk);
        end
        fail_now("idle_timeout");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [NREQ-1:0]   req;
        logic [WORD_W-1:0] word;
        int                stall;
        logic [NREQ-1:0]   exp_gnt;
        int                exp_count;
    } vec_t;
    vec_t vecs[6];

    initial begin
        logic [NREQ-1:0] g;
        time             t_last;

        vecs[0] = '{4'b0001, 8'b1101_1010, 0, 4'b0001, 2};
        vecs[1] = '{4'b1001, 8'hFF,        0, 4'b1000, 0};
        vecs[2] = '{4'b1001, 8'b0110_1101, 0, 4'b0001, 2};
        vecs[3] = '{4'b0110, 8'b1011_0110, 5, 4'b0010, 1};
        vecs[4] = '{4'b0011, 8'h00,        0, 4'b0001, 0};
        vecs[5] = '{4'b0100, 8'b1101_1101, 0, 4'b0100, 2};

        rst_n = 1'b0; req = '0; word_in = '0; res_ready = 1'b1;
        s_req = '0; s_word = '0; s_ready = 1'b1;
        t_last = 0;
        #1;
        check("rst_gnt", int'(gnt), 0);
        check("rst_det_clr", int'(det_clr), 0);
        check("rst_det_valid", int'(det_valid), 0);
        check("rst_det_d_in", int'(det_d_in), 0);
        check("rst_res_valid", int'(res_valid), 0);
        check("rst_res_id", int'(res_id), 0);
        check("rst_res_count", int'(res_count), 0);
        check("rst_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            word_in   = {NREQ{vecs[i].word}};
            req       = vecs[i].req;
            res_ready = (vecs[i].stall == 0);
            wait_gnt(30, g);
            check($sformatf("v%0d_gnt", i), int'(g), int'(vecs[i].exp_gnt));
            @(negedge clk);
            req = '0;
            wait_res(30);
            check($sformatf("v%0d_count", i), int'(res_count), vecs[i].exp_count);
            if (vecs[i].stall > 0) begin
                repeat (vecs[i].stall) begin
                    @(negedge clk);
                    req = '1;
                    #1;
                    check($sformatf("v%0d_stall_hold", i), int'({res_valid, busy, gnt}), int'({2'b11, 4'b0000}));
                end
                @(negedge clk);
                req       = '0;
                res_ready = 1'b1;
                #1;
                check($sformatf("v%0d_stall_valid", i), int'(res_valid), 1);
            end
            @(negedge clk);
            #1;
            check($sformatf("v%0d_back_idle", i), int'({res_valid, busy}), 0);
        end

        do_reset();
        word_in = {8'b1011_0110, 8'b0110_1101, 8'hFF, 8'b1101_1010};
        req     = '1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(20, g);
            check($sformatf("rr_gnt%0d", k), int'(g), 1 << (k % NREQ));
            if (k > 0) check($sformatf("rr_space%0d", k), int'(($time - t_last) / 10), WORD_W + DET_LAT + 3);
            t_last = $time;
            @(negedge clk);
        end
        req = '0;
        wait_idle(30);

        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            #1;
            check("idle_quiet", int'({gnt, det_valid, det_clr, busy}), 0);
        end
        @(negedge clk);
        word_in = {NREQ{8'b1101_1010}};
        req     = 4'b0100;
        #1;
        check("pulse_gnt", int'(gnt), int'(4'b0100));
        @(negedge clk);
        req = '0;
        wait_res(30);
        @(negedge clk);
        wait_idle(10);

        @(negedge clk);
        req = 4'b0001;
        wait_gnt(5, g);
        @(negedge clk);
        req = '0;
        repeat (3) @(negedge clk);
        #1;
        check("mid_shift_valid", int'(det_valid), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_quiet", int'({det_valid, busy, res_valid, det_clr}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            #1;
            check("abandoned_no_result", int'(res_valid), 0);
        end
        @(negedge clk);
        req = 4'b1010;
        wait_gnt(5, g);
        check("post_rst_gnt", int'(g), int'(4'b0010));
        @(negedge clk);
        req = '0;
        wait_res(30);
        @(negedge clk);
        wait_idle(10);

        @(negedge clk);
        s_word = {NREQ{8'b1101_1010}};
        s_req  = 4'b0001;
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 5 && !seen; n++) begin
                #1;
                if (s_gnt != '0) seen = 1'b1;
                @(negedge clk);
            end
            if (!seen) fail_now("sat_gnt_timeout");
            s_req = '0;
            seen  = 1'b0;
            for (int n = 0; n < 30 && !seen; n++) begin
                #1;
                if (s_rv) seen = 1'b1;
                else @(negedge clk);
            end
            if (!seen) fail_now("sat_res_timeout");
            check("sat_count", int'(s_rcnt), exp_hits(8'b1101_1010, 1));
            check("sat_id", int'(s_rid), 0);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
